// File: rtl/melody_sequencer.sv
// Note-memory driven melody player: steps through stored entries, driving the
// tone generator's half-period with timed notes separated by silent gaps.
module melody_sequencer #(
  parameter int CLK_F     = 200,
  parameter int TICK_US   = 1000,
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 10,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [31:0]   period,
  output logic          tone_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] note_idx
);

  localparam logic [31:0] TICK_LEN = 32'(CLK_F * TICK_US);
  localparam logic [31:0] GAP_LEN  = 32'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

  state_t        state_q;
  logic [31:0]   period_q;
  logic          tone_en_q;
  logic          done_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   presc_q;
  logic [9:0]    dur_q;
  logic [31:0]   gap_q;
  logic [15:0]   mem_q [DEPTH];

  // Semitone half-periods for C4..B4; codes outside 1..12 are rests.
  function automatic logic [31:0] base_half_period(input logic [3:0] code);
    case (code)
      4'd1:    return 32'd1911;
      4'd2:    return 32'd1804;
      4'd3:    return 32'd1703;
      4'd4:    return 32'd1607;
      4'd5:    return 32'd1517;
      4'd6:    return 32'd1432;
      4'd7:    return 32'd1351;
      4'd8:    return 32'd1276;
      4'd9:    return 32'd1204;
      4'd10:   return 32'd1136;
      4'd11:   return 32'd1073;
      4'd12:   return 32'd1012;
      default: return 32'd0;
    endcase
  endfunction

  logic [15:0] entry;
  logic [3:0]  ent_code;
  logic [1:0]  ent_oct;
  logic [9:0]  ent_dur;
  logic        is_note;
  logic        tick;
  logic        advance;
  logic        last_slot;
  logic        end_hit;

  assign entry     = mem_q[idx_q];
  assign ent_code  = entry[15:12];
  assign ent_oct   = entry[11:10];
  assign ent_dur   = entry[9:0];
  assign is_note   = (ent_code >= 4'd1) && (ent_code <= 4'd12);
  assign tick      = ((state_q == S_PLAY) || (state_q == S_GAP)) && (presc_q == TICK_LEN - 32'd1);
  assign last_slot = (idx_q == AW'(DEPTH - 1));
  assign advance   = tick && (((state_q == S_PLAY) && (dur_q == 10'd1) && (GAP_TICKS == 0)) ||
                              ((state_q == S_GAP) && (gap_q == 32'd1)));
  assign end_hit   = ((state_q == S_FETCH) && (ent_dur == 10'd0)) || (advance && last_slot);

  // NOTE: storage arrays carry no reset; the song must survive RESET_N, and an
  // array reset would also turn the RAM into a bank of flops.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values; later assignments below intentionally override.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      tone_en_q <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      presc_q   <= '0;
      dur_q     <= '0;
      gap_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q   <= S_IDLE;
        tone_en_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              idx_q   <= '0;
              state_q <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (ent_dur != 10'd0) begin
              dur_q     <= ent_dur;
              if (is_note) period_q <= base_half_period(ent_code) >> ent_oct;
              tone_en_q <= is_note;
              presc_q   <= '0;
              state_q   <= S_PLAY;
            end
          end
          S_PLAY: begin
            presc_q <= tick ? '0 : presc_q + 32'd1;
            if (tick) begin
              dur_q <= dur_q - 10'd1;
              if (dur_q == 10'd1) begin
                tone_en_q <= 1'b0;
                gap_q     <= GAP_LEN;
                state_q   <= S_GAP;
              end
            end
          end
          S_GAP: begin
            presc_q <= tick ? '0 : presc_q + 32'd1;
            if (tick) gap_q <= gap_q - 32'd1;
          end
        endcase

        if (advance && !last_slot) begin
          idx_q   <= idx_q + AW'(1);
          state_q <= S_FETCH;
        end
        // End marker, or advancing past the last slot: wrap when looping,
        // except a song that ends at slot 0 would spin forever.
        if (end_hit) begin
          if (loop && (idx_q != '0)) begin
            idx_q   <= '0;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign period   = period_q;
  assign tone_en  = tone_en_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: expected per-cycle outputs are queued
// from the timing rules when stimulus is driven and compared on falling edges.
module tb_melody_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [31:0] period;
  logic        tone_en;
  logic        busy;
  logic        done;
  logic [1:0]  note_idx;

  melody_sequencer #(
    .CLK_F(2), .TICK_US(1), .DEPTH(4), .GAP_TICKS(1)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop),
    .period(period), .tone_en(tone_en), .busy(busy), .done(done),
    .note_idx(note_idx)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] period;
    logic [4:0]  flags;   // {tone_en, busy, done, note_idx}
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input logic [31:0] p, input logic t, input logic b,
                      input logic d, input logic [1:0] idx);
    exp_t e;
    e.period = p;
    e.flags  = {t, b, d, idx};
    repeat (n) sb_q.push_back(e);
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] p, input logic [4:0] f);
    check({tag, "/period"}, period, p);
    check({tag, "/flags"}, {27'd0, tone_en, busy, done, note_idx}, {27'd0, f});
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (sb_q.size() > 0) begin
      @(negedge CLK);
      e = sb_q.pop_front();
      check_outputs($sformatf("%s@%0d", tag, cyc), e.period, e.flags);
      cyc++;
    end
  endtask

  task automatic write_slot(input logic [1:0] a, input logic [3:0] c, input logic [1:0] o,
                            input logic [9:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {c, o, d};
    @(negedge CLK);
    wr_en   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  logic [3:0]  codes [4];
  logic [31:0] pers  [4];
  logic [31:0] prev;

  initial begin
    codes = '{4'd1, 4'd3, 4'd5, 4'd8};
    pers  = '{32'd1911, 32'd1703, 32'd1517, 32'd1276};

    // Reset values, while held and just after release.
    repeat (2) @(negedge CLK);
    check_outputs("reset_held", 32'd0, 5'b0);
    RESET_N = 1'b1;
    @(negedge CLK);
    check_outputs("reset_rel", 32'd0, 5'b0);

    // 1: basic two-note song.
    write_slot(2'd0, 4'd10, 2'd0, 10'd3);
    write_slot(2'd1, 4'd1,  2'd1, 10'd2);
    write_slot(2'd2, 4'd0,  2'd0, 10'd0);
    do_start();
    push(1,    0, 0, 1, 0, 0);
    push(6, 1136, 1, 1, 0, 0);
    push(2, 1136, 0, 1, 0, 0);
    push(1, 1136, 0, 1, 0, 1);
    push(4,  955, 1, 1, 0, 1);
    push(2,  955, 0, 1, 0, 1);
    push(1,  955, 0, 1, 0, 2);
    push(1,  955, 0, 0, 1, 2);
    push(1,  955, 0, 0, 0, 2);
    drain("basic");

    // 2: rest entries keep period and stay silent.
    write_slot(2'd0, 4'd0,  2'd0, 10'd2);
    write_slot(2'd1, 4'd13, 2'd0, 10'd1);
    write_slot(2'd2, 4'd0,  2'd0, 10'd0);
    do_start();
    push(1, 955, 0, 1, 0, 0);
    push(6, 955, 0, 1, 0, 0);
    push(1, 955, 0, 1, 0, 1);
    push(4, 955, 0, 1, 0, 1);
    push(1, 955, 0, 1, 0, 2);
    push(1, 955, 0, 0, 1, 2);
    push(1, 955, 0, 0, 0, 2);
    drain("rest");

    // 3: loop over all slots, then drop loop for the second pass.
    for (int i = 0; i < 4; i++) write_slot(2'(i), codes[i], 2'd0, 10'd1);
    loop = 1'b1;
    do_start();
    prev = 32'd955;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        push(1, prev,    0, 1, 0, 2'(i));
        push(2, pers[i], 1, 1, 0, 2'(i));
        push(2, pers[i], 0, 1, 0, 2'(i));
        prev = pers[i];
        if (r == 1 && i == 1) begin
          drain("loop");
          loop = 1'b0;
        end
      end
    end
    push(1, 1276, 0, 0, 1, 3);
    push(1, 1276, 0, 0, 0, 3);
    drain("loop_end");

    // 4: stop in the second tick of a d=5 note, with a colliding start.
    write_slot(2'd0, 4'd12, 2'd2, 10'd5);
    write_slot(2'd1, 4'd0,  2'd0, 10'd0);
    do_start();
    push(1, 1276, 0, 1, 0, 0);
    push(3,  253, 1, 1, 0, 0);
    drain("stop_pre");
    stop  = 1'b1;
    start = 1'b1;
    push(1, 253, 0, 0, 0, 0);
    drain("stop");
    stop  = 1'b0;
    start = 1'b0;
    push(2, 253, 0, 0, 0, 0);
    drain("stop_post");

    // 5: slot-0 end marker finishes even when looping.
    write_slot(2'd0, 4'd0, 2'd0, 10'd0);
    loop = 1'b1;
    do_start();
    push(1, 253, 0, 1, 0, 0);
    push(1, 253, 0, 0, 1, 0);
    push(1, 253, 0, 0, 0, 0);
    drain("slot0_end");
    loop = 1'b0;

    // 6: asynchronous reset mid-note; memory survives and replays.
    write_slot(2'd0, 4'd5, 2'd0, 10'd3);
    write_slot(2'd1, 4'd0, 2'd0, 10'd0);
    do_start();
    push(1,  253, 0, 1, 0, 0);
    push(2, 1517, 1, 1, 0, 0);
    drain("pre_reset");
    RESET_N = 1'b0;
    #1;
    check_outputs("async_reset", 32'd0, 5'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    check_outputs("after_reset", 32'd0, 5'b0);
    do_start();
    push(1,    0, 0, 1, 0, 0);
    push(6, 1517, 1, 1, 0, 0);
    push(2, 1517, 0, 1, 0, 0);
    push(1, 1517, 0, 1, 0, 1);
    push(1, 1517, 0, 0, 1, 1);
    push(1, 1517, 0, 0, 0, 1);
    drain("replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
